// File: rtl/spi_mem_responder_pkg.sv
// Shared definitions for the SPI serial-RAM responder: command opcodes,
// address length, FSM state and transfer-mode encodings.
package spi_mem_responder_pkg;

    localparam logic [7:0] SPI_CMD_READ      = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE     = 8'h02;
    localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;

    localparam int         SPI_ADDR_BYTES = 3;
    localparam logic [1:0] SPI_ADDR_LAST  = 2'(SPI_ADDR_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA_RD,
        ST_DATA_WR,
        ST_IGNORE
    } spi_state_t;

    typedef enum logic [1:0] {
        MODE_READ,
        MODE_WRITE,
        MODE_FAST_READ
    } spi_mode_t;

    // Mode only matters for opcodes the FSM accepts; others go to IGNORE.
    function automatic spi_mode_t cmd_mode(input logic [7:0] cmd);
        if (cmd == SPI_CMD_WRITE)
            return MODE_WRITE;
        else if (cmd == SPI_CMD_FAST_READ)
            return MODE_FAST_READ;
        else
            return MODE_READ;
    endfunction

endpackage

// File: rtl/spi_mem_responder_edge_sync.sv
// Multi-flop synchronizers for sclk/cs_n/mosi plus sclk edge detection
// on the synchronized clock value.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n_sync,
    output logic mosi_sync
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync   <= '0;
            cs_n_sync_q <= '1;
            mosi_sync_q <= '0;
            sclk_p1     <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_p1     <= sclk_sync[SYNC_STAGES-1];
        end
    end

    // mosi shares the sclk depth, so it is aligned with the detected rise.
    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_p1;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_p1;
    assign cs_n_sync = cs_n_sync_q[SYNC_STAGES-1];
    assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 serial-RAM responder (READ 0x03, WRITE 0x02, 24-bit address).
// Define SPI_RESP_FAST_READ_EN to also accept FAST READ 0x0B (one dummy byte).
module spi_mem_responder
    import spi_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       busy,
    output logic       txn_done,
    output logic [7:0] bytes_written
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_n_s;
    logic mosi_s;

    spi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_n_sync(cs_n_s),
        .mosi_sync(mosi_s)
    );

    spi_state_t  state_q;
    spi_state_t  state_d;
    spi_mode_t   mode_q;
    logic [6:0]  rx_sh_q;
    logic [7:0]  tx_byte_q;
    logic [7:0]  bw_q;
    logic [2:0]  bit_cnt_q;
    logic [1:0]  addr_cnt_q;
    logic [23:0] addr_q;
    logic        got_byte_q;
    logic        miso_q;
    logic        txn_done_q;
    logic [7:0]  mem_q [DEPTH];

    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        cmd_ok;
    logic [23:0] addr_shift;
    logic [23:0] addr_inc;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        rx_byte    = {rx_sh_q, mosi_s};
        byte_done  = (state_q != ST_IDLE) && !cs_n_s && sclk_rise && (bit_cnt_q == 3'd7);
        addr_shift = {addr_q[15:0], rx_byte};
        addr_inc   = addr_q;
        addr_inc[AW-1:0] = addr_q[AW-1:0] + AW'(1);
`ifdef SPI_RESP_FAST_READ_EN
        cmd_ok = rx_byte inside {SPI_CMD_READ, SPI_CMD_WRITE, SPI_CMD_FAST_READ};
`else
        cmd_ok = rx_byte inside {SPI_CMD_READ, SPI_CMD_WRITE};
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!cs_n_s) state_d = ST_CMD;
            ST_CMD:   if (byte_done) state_d = cmd_ok ? ST_ADDR : ST_IGNORE;
            ST_ADDR: begin
                if (byte_done && addr_cnt_q == SPI_ADDR_LAST) begin
                    if (mode_q == MODE_WRITE)
                        state_d = ST_DATA_WR;
                    else if (mode_q == MODE_FAST_READ)
                        state_d = ST_DUMMY;
                    else
                        state_d = ST_DATA_RD;
                end
            end
            ST_DUMMY: if (byte_done) state_d = ST_DATA_RD;
            default:  state_d = state_q;
        endcase
        // Deselect overrides any in-flight byte, including one completing now.
        if (state_q != ST_IDLE && cs_n_s)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_READ;
            rx_sh_q    <= '0;
            tx_byte_q  <= '0;
            bw_q       <= '0;
            bit_cnt_q  <= '0;
            addr_cnt_q <= '0;
            addr_q     <= '0;
            got_byte_q <= 1'b0;
            miso_q     <= 1'b0;
            txn_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 8'h00;
        end else begin
            txn_done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                bit_cnt_q  <= '0;
                addr_cnt_q <= '0;
                got_byte_q <= 1'b0;
                miso_q     <= 1'b0;
                if (!cs_n_s)
                    bw_q <= '0;
            end else if (cs_n_s) begin
                miso_q     <= 1'b0;
                txn_done_q <= got_byte_q;
            end else begin
                if (sclk_rise) begin
                    rx_sh_q   <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (byte_done)
                    got_byte_q <= 1'b1;
                case (state_q)
                    ST_CMD: if (byte_done) mode_q <= cmd_mode(rx_byte);
                    ST_ADDR: begin
                        if (byte_done) begin
                            addr_q     <= addr_shift;
                            addr_cnt_q <= addr_cnt_q + 2'd1;
                            if (addr_cnt_q == SPI_ADDR_LAST && mode_q == MODE_READ)
                                tx_byte_q <= mem_q[addr_shift[AW-1:0]];
                        end
                    end
                    ST_DUMMY: if (byte_done) tx_byte_q <= mem_q[addr_q[AW-1:0]];
                    ST_DATA_RD: begin
                        // The eighth fall shifts out bit 0 and stages the next byte.
                        if (sclk_fall) begin
                            miso_q <= tx_byte_q[7];
                            if (bit_cnt_q == 3'd7) begin
                                addr_q    <= addr_inc;
                                tx_byte_q <= mem_q[addr_inc[AW-1:0]];
                            end else begin
                                tx_byte_q <= {tx_byte_q[6:0], 1'b0};
                            end
                        end
                    end
                    ST_DATA_WR: begin
                        if (byte_done) begin
                            mem_q[addr_q[AW-1:0]] <= rx_byte;
                            addr_q                <= addr_inc;
                            bw_q                  <= sat_inc(bw_q);
                        end
                    end
                    default: miso_q <= 1'b0;
                endcase
            end
        end
    end

    assign miso          = miso_q;
    assign busy          = (state_q != ST_IDLE);
    assign txn_done      = txn_done_q;
    assign bytes_written = bw_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Scoreboard bench for spi_mem_responder: a bus driver queues expected miso
// bytes and per-transaction bytes_written; two monitors pop and compare.
module tb_spi_mem_responder;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       busy;
    logic       txn_done;
    logic [7:0] bytes_written;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_miso[$];
    logic [7:0] exp_bw[$];

    logic [7:0] mon_sh = 8'h00;
    int         mon_n  = 0;

    always #5 clk = ~clk;

    spi_mem_responder #(
        .DEPTH(64),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .busy         (busy),
        .txn_done     (txn_done),
        .bytes_written(bytes_written)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // miso monitor: assembles each full byte seen while selected.
    always @(posedge sclk or negedge cs_n) begin
        if (!sclk) begin
            mon_n = 0;
        end else if (!cs_n) begin
            mon_sh = {mon_sh[6:0], miso};
            mon_n++;
            if (mon_n == 8) begin
                mon_n = 0;
                if (exp_miso.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_unexpected_byte: got %0h expected none", mon_sh);
                end else begin
                    check("miso_byte", {24'h0, mon_sh}, {24'h0, exp_miso.pop_front()});
                end
            end
        end
    end

    // Transaction monitor: each txn_done pulse consumes one expected bytes_written.
    always @(negedge clk) begin
        if (txn_done === 1'b1) begin
            if (exp_bw.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL txn_done_unexpected: got pulse expected none");
            end else begin
                check("bytes_written", {24'h0, bytes_written}, {24'h0, exp_bw.pop_front()});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_cyc(HALF);
            sclk = 1'b1;
            wait_cyc(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic [7:0] exp);
        exp_miso.push_back(exp);
        shift_bits(b, 8);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_cyc(2 * HALF);
        check("busy_selected", {31'h0, busy}, 32'h1);
    endtask

    task automatic cs_end(input logic [7:0] bw);
        wait_cyc(HALF);
        exp_bw.push_back(bw);
        cs_n = 1'b1;
        wait_cyc(3 * HALF);
        check("miso_deselected", {31'h0, miso}, 32'h0);
        check("busy_deselected", {31'h0, busy}, 32'h0);
    endtask

    task automatic do_write(input logic [23:0] a, input logic [23:0] d, input int n,
                            input int partial);
        cs_begin();
        xfer(8'h02, 8'h00);
        xfer(a[23:16], 8'h00);
        xfer(a[15:8], 8'h00);
        xfer(a[7:0], 8'h00);
        for (int i = 0; i < n; i++)
            xfer(d[23-8*i -: 8], 8'h00);
        if (partial > 0)
            shift_bits(8'h5A, partial);
        cs_end(8'(n));
    endtask

    task automatic do_read(input logic [23:0] a, input logic [23:0] d, input int n);
        cs_begin();
        xfer(8'h03, 8'h00);
        xfer(a[23:16], 8'h00);
        xfer(a[15:8], 8'h00);
        xfer(a[7:0], 8'h00);
        for (int i = 0; i < n; i++)
            xfer(8'h00, d[23-8*i -: 8]);
        cs_end(8'h00);
    endtask

    initial begin
        #5000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        wait_cyc(5);
        check("reset_miso", {31'h0, miso}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_txn_done", {31'h0, txn_done}, 32'h0);
        check("reset_bytes_written", {24'h0, bytes_written}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Write then read back three bytes at 0x10.
        do_write(24'h000010, 24'hAA55C3, 3, 0);
        do_read(24'h000010, 24'hAA55C3, 3);

        // Address wrap at the top of the array.
        do_write(24'h00003E, 24'h112233, 3, 0);
        do_read(24'h00003F, 24'h223300, 2);
        do_read(24'h00003E, 24'h112233, 3);

        // Partial trailing byte is dropped.
        do_write(24'h000020, 24'h770000, 1, 4);
        do_read(24'h000020, 24'h770000, 2);

        // Unknown command: everything ignored, memory untouched.
        cs_begin();
        xfer(8'h9F, 8'h00);
        xfer(8'h02, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h10, 8'h00);
        xfer(8'hEE, 8'h00);
        xfer(8'hEE, 8'h00);
        cs_end(8'h00);
        do_read(24'h000010, 24'hAA55C3, 3);

        // FAST READ: dummy byte, then data only when the feature is built in.
        cs_begin();
        xfer(8'h0B, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h10, 8'h00);
        xfer(8'hFF, 8'h00);
`ifdef SPI_RESP_FAST_READ_EN
        xfer(8'h00, 8'hAA);
        xfer(8'h00, 8'h55);
`else
        xfer(8'h00, 8'h00);
        xfer(8'h00, 8'h00);
`endif
        cs_end(8'h00);

        // Reset in the middle of a READ data byte.
        cs_begin();
        xfer(8'h03, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h10, 8'h00);
        shift_bits(8'h00, 2);
        wait_cyc(HALF);
        check("miso_before_reset", {31'h0, miso}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("miso_in_reset", {31'h0, miso}, 32'h0);
        check("busy_in_reset", {31'h0, busy}, 32'h0);
        check("txn_done_in_reset", {31'h0, txn_done}, 32'h0);
        check("bytes_written_in_reset", {24'h0, bytes_written}, 32'h0);
        cs_n = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);

        // Reset clears the array.
        do_read(24'h000010, 24'h000000, 1);

        wait_cyc(10);
        check("miso_queue_drained", 32'(exp_miso.size()), 32'h0);
        check("txn_queue_drained", 32'(exp_bw.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
